// File: rtl/video_timing_gen.sv
// Video timing generator: free-running raster counters, registered sync/DE
// outputs and a selectable built-in test pattern. Each line and each frame run
// active -> front porch -> sync -> back porch.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  pat_i,
    output logic        vout_de_o,
    output logic        vout_hs_o,
    output logic        vout_vs_o,
    output logic [23:0] vout_data_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit boundaries so a total of exactly 4096 still compares correctly
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Pixel colour for the selected pattern at the current active position
    function automatic logic [23:0] pattern_pixel(input logic [1:0] pat,
                                                  input logic [2:0] bar,
                                                  input logic [7:0] x,
                                                  input logic       y5);
        logic [23:0] px;
        px = 24'h000000;
        case (pat)
            2'd0: px = 24'h000000;
            2'd1: begin
                case (bar)
                    3'd0:    px = 24'hFFFFFF;
                    3'd1:    px = 24'hFFFF00;
                    3'd2:    px = 24'h00FFFF;
                    3'd3:    px = 24'h00FF00;
                    3'd4:    px = 24'hFF00FF;
                    3'd5:    px = 24'hFF0000;
                    3'd6:    px = 24'h0000FF;
                    default: px = 24'h000000;
                endcase
            end
            2'd2: px = {3{x}};
            default: px = (x[5] ^ y5) ? 24'hFFFFFF : 24'h000000;
        endcase
        return px;
    endfunction

    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [11:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q, pat_d;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [23:0] data_q, data_d;
    logic [11:0] x_q, x_d, y_q, y_d;

    logic        frame_first, h_wrap, v_wrap, h_act, v_act, in_hs, in_vs;
    logic [1:0]  pat_eff;

    // Counter state decode; the new pattern applies from pixel (0,0) itself
    always_comb begin
        frame_first = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        h_wrap      = ({1'b0, h_cnt_q} == H_LAST);
        v_wrap      = ({1'b0, v_cnt_q} == V_LAST);
        h_act       = ({1'b0, h_cnt_q} < H_ACT);
        v_act       = ({1'b0, v_cnt_q} < V_ACT);
        in_hs       = ({1'b0, h_cnt_q} >= HS_BEG) && ({1'b0, h_cnt_q} < HS_END);
        in_vs       = ({1'b0, v_cnt_q} >= VS_BEG) && ({1'b0, v_cnt_q} < VS_END);
        pat_eff     = (en_i && frame_first) ? pat_i : pat_q;
    end

    // Raster counters, colour-bar counter and frame-latched pattern select
    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        pat_d     = pat_q;
        if (!en_i) begin
            h_cnt_d   = 12'd0;
            v_cnt_d   = 12'd0;
            bar_cnt_d = 12'd0;
            bar_idx_d = 3'd0;
        end else begin
            h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
            if (h_wrap) begin
                v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
            end
            // bar index steps every H_ACTIVE/8 pixels; rolls 7->0 at end of active
            if (h_act) begin
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = 12'd0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 12'd1;
                end
            end else begin
                bar_cnt_d = 12'd0;
                bar_idx_d = 3'd0;
            end
            if (frame_first) begin
                pat_d = pat_i;
            end
        end
    end

    // Next output values, one cycle behind the counter state
    always_comb begin
        de_d   = 1'b0;
        hs_d   = ~HS_ON;
        vs_d   = ~VS_ON;
        data_d = 24'h0;
        x_d    = 12'd0;
        y_d    = 12'd0;
        fs_d   = 1'b0;
        if (en_i) begin
            de_d = h_act && v_act;
            hs_d = in_hs ? HS_ON : ~HS_ON;
            vs_d = in_vs ? VS_ON : ~VS_ON;
            fs_d = frame_first;
            if (h_act && v_act) begin
                x_d    = h_cnt_q;
                y_d    = v_cnt_q;
                data_d = pattern_pixel(pat_eff, bar_idx_q, h_cnt_q[7:0], v_cnt_q[5]);
            end
        end
    end

    // State and output registers; reset wins over enable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q   <= 12'd0;
            v_cnt_q   <= 12'd0;
            bar_cnt_q <= 12'd0;
            bar_idx_q <= 3'd0;
            pat_q     <= 2'd0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_ON;
            vs_q      <= ~VS_ON;
            data_q    <= 24'h0;
            x_q       <= 12'd0;
            y_q       <= 12'd0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            data_q    <= data_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fs_q      <= fs_d;
        end
    end

    assign vout_de_o     = de_q;
    assign vout_hs_o     = hs_q;
    assign vout_vs_o     = vs_q;
    assign vout_data_o   = data_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-raster instance (80x15 total, 64x8 active)
// with both sync polarities, plus a default 1080p instance for first-line checks.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic [1:0] pat = 2'd0;

    always #5 clk = ~clk;

    logic        s_de, s_hs, s_vs, s_fs, n_de, n_hs, n_vs, n_fs, d_de, d_hs, d_vs, d_fs;
    logic [23:0] s_data, n_data, d_data;
    logic [11:0] s_x, s_y, n_x, n_y, d_x, d_y;

    video_timing_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6),
                       .V_ACTIVE(8), .V_FP(2), .V_SYNC(3), .V_BP(2),
                       .HS_POL(1), .VS_POL(1)) dut_s (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pat_i(pat),
        .vout_de_o(s_de), .vout_hs_o(s_hs), .vout_vs_o(s_vs), .vout_data_o(s_data),
        .x_o(s_x), .y_o(s_y), .frame_start_o(s_fs));

    video_timing_gen #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6),
                       .V_ACTIVE(8), .V_FP(2), .V_SYNC(3), .V_BP(2),
                       .HS_POL(0), .VS_POL(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pat_i(pat),
        .vout_de_o(n_de), .vout_hs_o(n_hs), .vout_vs_o(n_vs), .vout_data_o(n_data),
        .x_o(n_x), .y_o(n_y), .frame_start_o(n_fs));

    video_timing_gen dut_d (
        .clk_i(clk), .rst_i(rst), .en_i(en), .pat_i(pat),
        .vout_de_o(d_de), .vout_hs_o(d_hs), .vout_vs_o(d_vs), .vout_data_o(d_data),
        .x_o(d_x), .y_o(d_y), .frame_start_o(d_fs));

    // Packed observation {de, hs(active=1), vs(active=1), fs, x, y, data}
    logic [51:0] obs_s, obs_n, obs_d;
    assign obs_s = {s_de, s_hs, s_vs, s_fs, s_x, s_y, s_data};
    assign obs_n = {n_de, ~n_hs, ~n_vs, n_fs, n_x, n_y, n_data};
    assign obs_d = {d_de, d_hs, d_vs, d_fs, d_x, d_y, d_data};

    int checks = 0;
    int errors = 0;

    function automatic logic [23:0] bar_color(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pix(input int p, input int h, input int v, input int barw);
        case (p)
            1: return bar_color(h / barw);
            2: return {3{h[7:0]}};
            3: return (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected small-raster outputs for linear pixel number n (from frame start)
    function automatic logic [51:0] model_s(input int n, input int p);
        int h, v;
        logic de, hs, vs, fs;
        logic [11:0] x, y;
        logic [23:0] d;
        h  = n % 80;
        v  = (n / 80) % 15;
        de = (h < 64) && (v < 8);
        hs = (h >= 68) && (h < 74);
        vs = (v >= 10) && (v < 13);
        fs = (h == 0) && (v == 0);
        x  = de ? 12'(h) : 12'd0;
        y  = de ? 12'(v) : 12'd0;
        d  = de ? pix(p, h, v, 8) : 24'd0;
        return {de, hs, vs, fs, x, y, d};
    endfunction

    // Expected default-raster outputs on line 0
    function automatic logic [51:0] model_d0(input int h, input int p);
        logic de, hs, fs;
        logic [11:0] x;
        logic [23:0] d;
        de = (h < 1920);
        hs = (h >= 2008) && (h < 2052);
        fs = (h == 0);
        x  = de ? 12'(h) : 12'd0;
        d  = de ? pix(p, h, 0, 240) : 24'd0;
        return {de, hs, 1'b0, fs, x, 12'd0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset with enable high; afterwards edge k shows pixel k-1
    task automatic restart(input logic [1:0] p);
        rst = 1'b1;
        en  = 1'b1;
        pat = p;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        pat = 2'd3;
        repeat (3) tick();
        checks++; if (s_de !== 1'b0) begin errors++; $display("FAIL reset_de got=%b exp=0", s_de); end
        checks++; if (s_hs !== 1'b0) begin errors++; $display("FAIL reset_hs got=%b exp=0", s_hs); end
        checks++; if (s_vs !== 1'b0) begin errors++; $display("FAIL reset_vs got=%b exp=0", s_vs); end
        checks++; if (s_data !== 24'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", s_data); end
        checks++; if (s_x !== 12'd0 || s_y !== 12'd0) begin errors++; $display("FAIL reset_xy got=%0d,%0d exp=0,0", s_x, s_y); end
        checks++; if (s_fs !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", s_fs); end
        checks++; if (n_hs !== 1'b1 || n_vs !== 1'b1) begin errors++; $display("FAIL reset_neg_sync got=%b%b exp=11", n_hs, n_vs); end
        checks++; if (obs_d !== 52'd0) begin errors++; $display("FAIL reset_default got=%h exp=0", obs_d); end
    endtask

    task automatic test_free_run();
        int de_cnt, fs_cnt, fs_last;
        de_cnt = 0; fs_cnt = 0; fs_last = -1;
        restart(2'd2);
        for (int k = 1; k <= 2400; k++) begin
            tick();
            checks++;
            if (obs_s !== model_s(k - 1, 2)) begin
                errors++;
                if (errors <= 20) $display("FAIL free_run n=%0d got=%h exp=%h", k - 1, obs_s, model_s(k - 1, 2));
            end
            checks++;
            if (obs_n !== model_s(k - 1, 2)) begin
                errors++;
                if (errors <= 20) $display("FAIL neg_pol n=%0d got=%h exp=%h", k - 1, obs_n, model_s(k - 1, 2));
            end
            if (s_de === 1'b1) de_cnt++;
            if (s_fs === 1'b1) begin
                fs_cnt++;
                if (fs_last >= 0) begin
                    checks++;
                    if (k - fs_last !== 1200) begin
                        errors++;
                        $display("FAIL fs_period got=%0d exp=1200", k - fs_last);
                    end
                end
                fs_last = k;
            end
        end
        checks++; if (de_cnt !== 1024) begin errors++; $display("FAIL de_count got=%0d exp=1024", de_cnt); end
        checks++; if (fs_cnt !== 2) begin errors++; $display("FAIL fs_count got=%0d exp=2", fs_cnt); end
    endtask

    task automatic test_colorbar();
        restart(2'd1);
        for (int k = 1; k <= 2200; k++) begin
            tick();
            checks++;
            if (obs_d !== model_d0(k - 1, 1)) begin
                errors++;
                if (errors <= 20) $display("FAIL bars_1080p h=%0d got=%h exp=%h", k - 1, obs_d, model_d0(k - 1, 1));
            end
            if (k <= 1200) begin
                checks++;
                if (obs_s !== model_s(k - 1, 1)) begin
                    errors++;
                    if (errors <= 20) $display("FAIL bars_small n=%0d got=%h exp=%h", k - 1, obs_s, model_s(k - 1, 1));
                end
            end
        end
    endtask

    task automatic test_pat_change();
        int p;
        restart(2'd1);
        for (int k = 1; k <= 2400; k++) begin
            if (k == 251) pat = 2'd3;
            tick();
            p = (k - 1 < 1200) ? 1 : 3;
            checks++;
            if (obs_s !== model_s(k - 1, p)) begin
                errors++;
                if (errors <= 20) $display("FAIL pat_change n=%0d got=%h exp=%h", k - 1, obs_s, model_s(k - 1, p));
            end
        end
    endtask

    task automatic test_disable();
        restart(2'd2);
        for (int k = 1; k <= 430; k++) begin
            tick();
            checks++;
            if (obs_s !== model_s(k - 1, 2)) begin
                errors++;
                if (errors <= 20) $display("FAIL pre_disable n=%0d got=%h exp=%h", k - 1, obs_s, model_s(k - 1, 2));
            end
        end
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (obs_s !== 52'd0 || obs_n !== 52'd0) begin
                errors++;
                $display("FAIL disable_idle cyc=%0d got=%h/%h exp=0", j, obs_s, obs_n);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 1200; j++) begin
            tick();
            checks++;
            if (obs_s !== model_s(j, 2)) begin
                errors++;
                if (errors <= 20) $display("FAIL re_enable n=%0d got=%h exp=%h", j, obs_s, model_s(j, 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        restart(2'd3);
        for (int k = 1; k <= 1199; k++) begin
            tick();
            checks++;
            if (obs_s !== model_s(k - 1, 3)) begin
                errors++;
                if (errors <= 20) $display("FAIL pre_reset n=%0d got=%h exp=%h", k - 1, obs_s, model_s(k - 1, 3));
            end
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs_s !== 52'd0 || obs_n !== 52'd0) begin
            errors++;
            $display("FAIL mid_reset_vals got=%h/%h exp=0", obs_s, obs_n);
        end
        rst = 1'b0;
        for (int j = 0; j < 100; j++) begin
            tick();
            checks++;
            if (obs_s !== model_s(j, 3)) begin
                errors++;
                if (errors <= 20) $display("FAIL post_reset n=%0d got=%h exp=%h", j, obs_s, model_s(j, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_colorbar();
        test_pat_change();
        test_disable();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
